// File: rtl/sha_digest_flit_packer.sv
// rtl/sha_digest_flit_packer.sv - packs SHA digest words into tagged 512-bit D2D flits
//
// Collects DIGEST_WORDS 32-bit digest words from the SHA core and emits each
// complete digest as one 512-bit flit:
//   [32*DIGEST_WORDS-1:0] digest words (word 0 in [31:0]), remaining lanes zero
//   [495:480]             16-bit sequence number
//   [511:496]             16'hD16E marker
// One flit sits in the output register while the next digest assembles; the
// core is stalled only when a completed digest is waiting behind a busy output.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   sha_dout       in   [31:0] digest word from SHA core
//   sha_dst_write  in   word valid from SHA core
//   sha_dst_ready  out  packer can accept a word this cycle
//   d2d_data_out   out  [511:0] outbound flit
//   d2d_valid_out  out  flit valid
//   d2d_ready_in   in   D2D adapter accepts the flit
//   drop_err       out  sticky: a word was written while sha_dst_ready was 0
module sha_digest_flit_packer #(
  parameter int DIGEST_WORDS = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  sha_dout,
  input  logic         sha_dst_write,
  output logic         sha_dst_ready,
  output logic [511:0] d2d_data_out,
  output logic         d2d_valid_out,
  input  logic         d2d_ready_in,
  output logic         drop_err
);

  localparam int         ASM_W     = 32 * DIGEST_WORDS;
  localparam logic [3:0] LAST_LANE = 4'(DIGEST_WORDS - 1);
  localparam logic [15:0] MARKER   = 16'hD16E;

  logic [3:0]       r_cnt;
  logic [ASM_W-1:0] r_asm;
  logic             r_pending;
  logic [15:0]      r_seq;
  logic             r_valid;
  logic [511:0]     r_data;
  logic             r_drop;

  logic             w_accept;
  logic             w_drain;
  logic             w_slot_free;
  logic             w_complete;
  logic             w_load;
  logic [ASM_W-1:0] w_asm_next;
  logic [511:0]     w_flit;

  // Ready depends only on the pending register, so nothing from d2d_ready_in
  // reaches the core combinationally.
  assign w_accept    = sha_dst_write && !r_pending;
  assign w_drain     = r_valid && d2d_ready_in;
  assign w_slot_free = !r_valid || d2d_ready_in;
  assign w_complete  = w_accept && (r_cnt == LAST_LANE);

  // A flit loads either straight from the completing edge (slot free) or from
  // the held assembly buffer when the output drains. Accept is blocked while
  // pending, so the two sources never coincide.
  assign w_load = (w_complete && w_slot_free) || (r_pending && w_drain);

  // Assembly view including the word accepted this edge, so a completing
  // digest can go to the output register without an extra cycle.
  always_comb begin
    w_asm_next = r_asm;
    for (int i = 0; i < DIGEST_WORDS; i++) begin
      if (w_accept && (r_cnt == 4'(i))) begin
        w_asm_next[32*i +: 32] = sha_dout;
      end
    end
  end

  // Sequence number is the one current at load time; loads happen in
  // completion order, so numbering follows digest order.
  assign w_flit = {MARKER, r_seq, 480'(w_asm_next)};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_asm     <= '0;
      r_pending <= 1'b0;
      r_seq     <= '0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_drop    <= 1'b0;
    end else begin
      r_asm <= w_asm_next;

      if (w_load) begin
        r_data    <= w_flit;
        r_seq     <= r_seq + 16'd1;
        r_cnt     <= '0;
        r_pending <= 1'b0;
      end else if (w_complete) begin
        // Output busy: keep the full digest in the assembly buffer.
        r_pending <= 1'b1;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 4'd1;
      end

      if (w_load) begin
        r_valid <= 1'b1;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end

      if (sha_dst_write && r_pending) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign sha_dst_ready = !r_pending;
  assign d2d_data_out  = r_data;
  assign d2d_valid_out = r_valid;
  assign drop_err      = r_drop;

endmodule

// File: doc/sha_digest_flit_packer.md
# sha_digest_flit_packer

Transmit-side packer between the SHA-2 core's destination port and the D2D adapter's outbound flit interface. Collects the 32-bit digest words emitted by the core and packs each complete digest, with a sequence tag, into one 512-bit flit. Presents the flit to the D2D side with a valid/ready handshake. Holds one flit in an output register while the next digest assembles, so the core stalls only when both slots are occupied.

## Interface
- DIGEST_WORDS, 8: 32-bit words per digest; legal range 1..15 (8 = SHA-256, 7 = SHA-224).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- sha_dout  in  32  digest word from SHA core.
- sha_dst_write  in  1  word valid from SHA core.
- sha_dst_ready  out  1  packer can accept a word this cycle.
- d2d_data_out  out  512  outbound flit.
- d2d_valid_out  out  1  flit valid.
- d2d_ready_in  in  1  D2D adapter accepts the flit.
- drop_err  out  1  sticky: a word was written while sha_dst_ready = 0.

## Operation
- Word accept: sha_dst_write && sha_dst_ready at a rising edge. The word is stored in assembly lane [32*cnt +: 32], and cnt increments.
- Flit format:
  - Word 0 occupies bits [31:0].
  - Lanes DIGEST_WORDS..14 are zero.
  - [495:480] = 16-bit sequence number.
  - [511:496] = 16'hD16E marker.
- Sequence number: starts at 0 after reset, increments by 1 per flit loaded into the output register, wraps 16'hFFFF -> 0.
- Completion: the edge that accepts word DIGEST_WORDS-1 completes the digest.
  - If the output slot is free at that edge (d2d_valid_out = 0, or d2d_valid_out && d2d_ready_in), the flit loads into the output register at that same edge and cnt returns to 0.
  - Otherwise the assembly buffer holds the flit and sets pending = 1.
- Pending: when pending = 1, the next output handshake (d2d_valid_out && d2d_ready_in) loads the pending flit into the output register at that edge, clears pending, and resets cnt to 0.
- sha_dst_ready = !pending. It is registered, with no combinational path from d2d_ready_in.
- Output register: d2d_valid_out is set when a flit loads. It clears on a handshake unless a new flit loads at the same edge, in which case it stays 1 and d2d_data_out updates.
- Data stability: d2d_data_out and d2d_valid_out are stable while d2d_valid_out && !d2d_ready_in.
- Drop: sha_dst_write while sha_dst_ready = 0 discards the word, leaves all state unchanged, and sets drop_err. drop_err clears only on reset.
- Reset (asynchronous, any time, including mid-digest or mid-handshake):
  - Clears cnt, pending, sequence number, d2d_valid_out, d2d_data_out and drop_err, all to 0.
  - sha_dst_ready = 1.
  - A partially assembled digest is discarded.

## Timing
- Latency: last word accepted at edge k gives d2d_valid_out = 1 in the cycle after edge k, when the slot is free.
- Throughput: with d2d_ready_in held at 1, one word per cycle is sustained with no bubbles, giving one flit per DIGEST_WORDS cycles.
- Stall: sha_dst_ready falls in the cycle after the completing edge when the slot is busy. It rises in the cycle after the draining handshake.
- Simultaneous completion and drain at the same edge: the new flit loads directly, pending stays 0, and d2d_valid_out stays 1.
- Simultaneous events are resolved within one edge. No word is lost and no flit is duplicated, under any combination of sha_dst_write, d2d_ready_in and the completion edge.

## Test plan
- Single digest, d2d_ready_in = 1, words 32'h1000_0000+i for i = 0..7 on consecutive cycles:
  - d2d_valid_out high for 1 cycle, one cycle after word 7.
  - data[255:0] = words in order, data[479:256] = 0, [495:480] = 0, [511:496] = 16'hD16E.
- Backpressure: d2d_ready_in = 0, send two full digests.
  - First flit holds stable with seq 0.
  - sha_dst_ready = 0 after the 16th word.
  - Raise d2d_ready_in for 1 cycle: flit seq 1 appears on the next cycle and sha_dst_ready returns to 1.
- Continuous streaming: d2d_ready_in = 1, 3 digests back-to-back.
  - sha_dst_ready never drops.
  - Flits carry seq 0, 1, 2.
- Drop: while pending, assert sha_dst_write with 32'hDEAD_BEEF.
  - drop_err = 1 and stays 1.
  - Word absent from all flits.
  - Next flit contents unchanged.
- Sequence wrap: stream 65537 digests.
  - Flit 65535 carries seq 16'hFFFF.
  - Flit 65536 carries seq 0.
- Reset mid-digest, after 5 words with one flit waiting:
  - All outputs 0 and sha_dst_ready = 1 immediately.
  - Next full digest yields seq 0 containing only new words.
